// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot-time writer for the SOPC instruction memory.
// Receives a framed byte stream (16-bit big-endian word count, 4*N data
// bytes MSB first, XOR checksum byte), writes each assembled word to
// consecutive word addresses, and keeps the CPU in reset until a frame
// with a correct checksum has been loaded.
//
// Handshake: a byte is transferred on every rising edge where
// rx_valid && rx_ready. rx_ready is a registered level that is high exactly
// while the loader sits in LEN_HI, LEN_LO, DATA or CHECK. The sender may
// present a new byte every cycle, and rx_valid may drop at any time.
module inst_rom_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  localparam int          IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic                rx_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                cpu_hold_q;
  logic                done_q;
  logic                error_q;
  logic [7:0]          len_hi_q;
  logic [15:0]         len_q;
  logic [15:0]         word_cnt_q;
  logic [1:0]          byte_idx_q;
  logic [23:0]         shift_q;
  logic [7:0]          xor_q;
  logic [IDLE_W-1:0]   idle_q;

  logic                accept;
  logic                in_rx;
  logic                start_load;
  logic                timed_out;
  logic [15:0]         n_rx;

  // Next-state decision: byte handshakes, length/checksum verdicts, timeout.
  always_comb begin
    accept     = rx_valid && rx_ready_q;
    in_rx      = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                 (state_q == S_DATA)   || (state_q == S_CHECK);
    start_load = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                           (state_q == S_ERROR));
    timed_out  = in_rx && !accept && (idle_q == IDLE_W'(TIMEOUT - 1));
    n_rx       = {len_hi_q, rx_data};
    state_d    = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (accept) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, n_rx} > CAPACITY) state_d = S_ERROR;
          else if (n_rx == 16'd0)      state_d = S_CHECK;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_idx_q == 2'd3) && (word_cnt_q + 16'd1 == len_q))
          state_d = S_CHECK;
      end
      S_CHECK: if (accept) state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
      default: state_d = S_IDLE;
    endcase
    if (timed_out) state_d = S_ERROR;
  end

  // State, datapath and registered outputs; reset abandons any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      len_hi_q    <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      xor_q       <= '0;
      idle_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                    (state_d == S_DATA)   || (state_d == S_CHECK);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);
      cpu_hold_q <= (state_d != S_DONE);
      mem_we_q   <= 1'b0;
      if (start_load) begin
        len_hi_q   <= '0;
        len_q      <= '0;
        word_cnt_q <= '0;
        byte_idx_q <= '0;
        xor_q      <= '0;
        idle_q     <= '0;
      end else if (accept) begin
        xor_q  <= xor_q ^ rx_data;
        idle_q <= '0;
        unique case (state_q)
          S_LEN_HI: len_hi_q <= rx_data;
          S_LEN_LO: len_q    <= n_rx;
          S_DATA: begin
            byte_idx_q <= byte_idx_q + 2'd1;
            shift_q    <= {shift_q[15:0], rx_data};
            if (byte_idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
              mem_wdata_q <= {shift_q, rx_data};
              word_cnt_q  <= word_cnt_q + 16'd1;
            end
          end
          default: ;
        endcase
      end else if (in_rx) begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: frame-level bench for inst_rom_loader with a small
// memory (4 words) and a short inter-byte timeout.
module tb_inst_rom_loader;

  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 8;
  localparam int CAP     = 1 << ADDR_W;
  localparam int WR_W    = ADDR_W + 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [2:0]        dbg_state;

  logic [WR_W-1:0] exp_q[$];
  logic [WR_W-1:0] mon_exp;
  logic [31:0]     words[4];
  int              n_cmp = 0;
  int              n_bad = 0;

  inst_rom_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every write strobe must match the next expected {addr, data}
  always @(negedge clk) begin
    if (rst && mem_we) begin
      if (exp_q.size() == 0) begin
        check("extra_write", 64'({mem_addr, mem_wdata}), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write", 64'({mem_addr, mem_wdata}), 64'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rx_ready"}, 64'(rx_ready), 64'd0);
    check({pfx, "_mem_we"}, 64'(mem_we), 64'd0);
    check({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({pfx, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check({pfx, "_done"}, 64'(done), 64'd0);
    check({pfx, "_error"}, 64'(error), 64'd0);
  endtask

  // driver: one-cycle start pulse
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_rx_ready", 64'(rx_ready), 64'd1);
    check("start_cpu_hold", 64'(cpu_hold), 64'd1);
    check("start_flags", 64'({done, error}), 64'd0);
  endtask

  // driver: idle for gap cycles (optionally pulsing start), then hand over one byte
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int w;
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = pulse && (g == 0);
      tick();
      start = 1'b0;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    w = 0;
    while (!rx_ready && w < 20) begin
      tick();
      w++;
    end
    if (!rx_ready) begin
      check("ready_wait", 64'd0, 64'd1);
      rx_valid = 1'b0;
      return;
    end
    tick();
    rx_valid = 1'b0;
  endtask

  // reference model + driver for a whole frame using words[0..n-1]
  task automatic run_frame(input logic [15:0] n, input int gap_lo, input int gap_hi,
                           input bit corrupt, input bit pulse);
    logic [7:0] fb[$];
    logic [7:0] chk;
    bit         over;
    bit         good;
    over = (int'(n) > CAP);
    fb.push_back(n[15:8]);
    fb.push_back(n[7:0]);
    if (!over) begin
      for (int k = 0; k < int'(n); k++) begin
        for (int j = 3; j >= 0; j--) fb.push_back(words[k][8*j +: 8]);
        exp_q.push_back({ADDR_W'(k), words[k]});
      end
      chk = 8'h00;
      foreach (fb[i]) chk = chk ^ fb[i];
      fb.push_back(corrupt ? (chk ^ 8'h18) : chk);
    end
    do_start();
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], int'($urandom_range(gap_lo, gap_hi)), pulse);
      if (!over && i >= 2 && i < fb.size() - 1 && ((i - 2) % 4 == 3))
        check("we_timing", 64'(mem_we), 64'd1);
    end
    good = !over && !corrupt;
    check("end_done", 64'(done), 64'(good));
    check("end_error", 64'(error), 64'(!good));
    check("end_cpu_hold", 64'(cpu_hold), 64'(!good));
    check("end_rx_ready", 64'(rx_ready), 64'd0);
    check("writes_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick();
    tick();
    check_reset_vals("por");
    rst = 1'b1;
    tick();

    // clean two-word load
    words[0] = 32'h3401_1100;
    words[1] = 32'h3402_0020;
    run_frame(16'd2, 0, 0, 1'b0, 1'b0);
    check("clean_last_addr", 64'(mem_addr), 64'd1);
    check("clean_last_data", 64'(mem_wdata), 64'h3402_0020);

    // same frame with a bad checksum: words still land, frame rejected
    run_frame(16'd2, 0, 0, 1'b1, 1'b0);

    // zero length, exact capacity, one past capacity
    run_frame(16'd0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) words[k] = $urandom;
    run_frame(16'd4, 0, 1, 1'b0, 1'b0);
    run_frame(16'd5, 0, 0, 1'b0, 1'b0);

    // throttled one-word frame with stray start pulses
    words[0] = $urandom;
    run_frame(16'd1, 3, 3, 1'b0, 1'b1);

    // stall after two data bytes: error exactly TIMEOUT cycles later
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      check("timeout_err", 64'(error), 64'(i == TIMEOUT));
    end
    check("timeout_hold", 64'({cpu_hold, rx_ready, done}), 64'b100);

    // stall in LEN_HI right after start
    do_start();
    for (int i = 1; i <= TIMEOUT; i++) tick();
    check("lenhi_timeout", 64'(error), 64'd1);

    // reset in the middle of a word
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_vals("postrst");
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h0000_0001;
    words[2] = 32'h8000_0000;
    run_frame(16'd3, 0, 0, 1'b0, 1'b0);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      logic [15:0] n;
      if ($urandom_range(0, 5) == 0) n = 16'($urandom_range(CAP + 1, 65535));
      else                           n = 16'($urandom_range(0, CAP));
      for (int k = 0; k < 4; k++) words[k] = $urandom;
      run_frame(n, 0, 3, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    tick();
    tick();
    check("final_writes_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
